classic_mode_core: RTL and testbench



---
 rtl/classic_mode_core.sv | 73 +++++++
 tb/tb_classic_mode_core.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/classic_mode_core.sv
// Classic-mode control core for the memory game: round sequencer, score counter
// and guess comparator. All control outputs are registered decodes of the state.
module classic_mode_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        play_again,
   input  logic        received_input,
   input  logic [31:0] game_pattern,
   input  logic [31:0] input_pattern,
   output logic        gen_pattern,
   output logic        input_handler_en,
   output logic        incr_score,
   output logic        clr,
   output logic        is_equal,
   output logic [15:0] count,
   output logic        game_over
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      GEN     = 3'd2,
      WAIT_IN = 3'd3,
      SCORE   = 3'd4,
      OVER    = 3'd5
   } state_t;

   state_t      state, nxt;
   logic [15:0] count_q;

   assign is_equal = received_input && (game_pattern == input_pattern);
   assign count    = count_q;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = CLEAR;
         CLEAR:   nxt = GEN;
         GEN:     nxt = WAIT_IN;
         WAIT_IN: if (received_input) nxt = is_equal ? SCORE : OVER;
         SCORE:   nxt = GEN;
         OVER:    if (play_again) nxt = CLEAR;
         default: nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         clr              <= 1'b0;
         gen_pattern      <= 1'b0;
         input_handler_en <= 1'b0;
         incr_score       <= 1'b0;
         game_over        <= 1'b0;
      end else begin
         state            <= nxt;
         clr              <= (nxt == CLEAR);
         gen_pattern      <= (nxt == GEN);
         input_handler_en <= (nxt == WAIT_IN);
         incr_score       <= (nxt == SCORE);
         game_over        <= (nxt == OVER);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          count_q <= 16'h0000;
      else if (clr)        count_q <= 16'h0000;
      else if (incr_score) count_q <= count_q + 16'h0001;
   end

endmodule

// File: tb/tb_classic_mode_core.sv
// Self-checking bench for classic_mode_core: directed steps plus randomized
// rounds, every cycle compared against a round-level reference model.
module tb_classic_mode_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        play_again = 1'b0;
   logic        received_input = 1'b0;
   logic [31:0] game_pattern = 32'h0;
   logic [31:0] input_pattern = 32'h0;
   logic        gen_pattern, input_handler_en, incr_score, clr, is_equal, game_over;
   logic [15:0] count;

   int compared = 0;
   int mismatched = 0;

   typedef enum {M_IDLE, M_CLEAR, M_GEN, M_WAIT, M_SCORE, M_OVER} mphase_t;
   mphase_t     ph = M_IDLE;
   int unsigned score = 0;

   classic_mode_core dut (
      .clk(clk), .rst_n(rst_n), .start(start), .play_again(play_again),
      .received_input(received_input), .game_pattern(game_pattern),
      .input_pattern(input_pattern), .gen_pattern(gen_pattern),
      .input_handler_en(input_handler_en), .incr_score(incr_score), .clr(clr),
      .is_equal(is_equal), .count(count), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".clr"},       {31'b0, clr},              {31'b0, ph == M_CLEAR});
      chk({tag, ".gen"},       {31'b0, gen_pattern},      {31'b0, ph == M_GEN});
      chk({tag, ".ih_en"},     {31'b0, input_handler_en}, {31'b0, ph == M_WAIT});
      chk({tag, ".incr"},      {31'b0, incr_score},       {31'b0, ph == M_SCORE});
      chk({tag, ".game_over"}, {31'b0, game_over},        {31'b0, ph == M_OVER});
      chk({tag, ".count"},     {16'b0, count},            score % 65536);
   endtask

   // One clock edge of the game rules, applied to the inputs present at that edge.
   task automatic model_step();
      if (!rst_n) begin
         ph = M_IDLE;
         score = 0;
      end else begin
         if (ph == M_CLEAR)      score = 0;
         else if (ph == M_SCORE) score = (score + 1) % 65536;
         case (ph)
            M_IDLE:  if (start) ph = M_CLEAR;
            M_CLEAR: ph = M_GEN;
            M_GEN:   ph = M_WAIT;
            M_WAIT:  if (received_input) ph = (game_pattern == input_pattern) ? M_SCORE : M_OVER;
            M_SCORE: ph = M_GEN;
            M_OVER:  if (play_again) ph = M_CLEAR;
            default: ph = M_IDLE;
         endcase
      end
   endtask

   task automatic tick(input string tag);
      #1;
      chk({tag, ".is_equal"}, {31'b0, is_equal},
          {31'b0, received_input && (game_pattern == input_pattern)});
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
   endtask

   task automatic hard_reset(input string tag);
      rst_n = 1'b0;
      start = 1'b0; play_again = 1'b0; received_input = 1'b0;
      #1;
      ph = M_IDLE;
      score = 0;
      check_outputs({tag, ".async"});
      tick({tag, ".hold"});
      rst_n = 1'b1;
   endtask

   task automatic correct_round(input string tag, input logic [31:0] pat);
      game_pattern = pat; input_pattern = pat; received_input = 1'b1;
      tick({tag, ".accept"});
      received_input = 1'b0;
      tick({tag, ".gen"});
      tick({tag, ".wait"});
   endtask

   initial begin
      #2;
      hard_reset("reset");
      for (int i = 0; i < 5; i++) tick("idle");
      chk("idle_count", {16'b0, count}, 32'h0);

      // Start sequence
      start = 1'b1;
      tick("start");
      chk("clr_pulse", {31'b0, clr}, 32'h1);
      start = 1'b0;
      tick("gen1");
      chk("gen_pulse", {31'b0, gen_pattern}, 32'h1);
      chk("clr_one_cycle", {31'b0, clr}, 32'h0);
      tick("wait1");
      tick("wait_hold");
      chk("ih_en_holds", {31'b0, input_handler_en}, 32'h1);

      // Correct round
      game_pattern = 32'h1; input_pattern = 32'h1; received_input = 1'b1;
      #1;
      chk("eq_same_cycle", {31'b0, is_equal}, 32'h1);
      tick("correct");
      chk("incr_pulse", {31'b0, incr_score}, 32'h1);
      received_input = 1'b0;
      tick("correct_gen");
      chk("count_one", {16'b0, count}, 32'h1);
      tick("correct_wait");

      // Wrong guess, then start must not matter
      game_pattern = 32'h2; input_pattern = 32'h3; received_input = 1'b1;
      #1;
      chk("neq", {31'b0, is_equal}, 32'h0);
      tick("wrong");
      chk("over", {31'b0, game_over}, 32'h1);
      received_input = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 3; i++) tick("over_start");
      start = 1'b0;
      chk("over_count_holds", {16'b0, count}, 32'h1);

      // Restart
      play_again = 1'b1;
      tick("again");
      play_again = 1'b0;
      tick("again_gen");
      chk("again_count_zero", {16'b0, count}, 32'h0);
      tick("again_wait");

      // Randomized play
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] g;
         g = $urandom;
         start          = ($urandom_range(0, 7) == 0);
         play_again     = ($urandom_range(0, 3) == 0);
         received_input = ($urandom_range(0, 2) == 0);
         game_pattern   = g;
         input_pattern  = ($urandom_range(0, 2) != 0) ? g : (g ^ (32'h1 << $urandom_range(0, 31)));
         tick("rand");
      end
      start = 1'b0; play_again = 1'b0; received_input = 1'b0;

      // Mid-game asynchronous reset
      hard_reset("rst2");
      start = 1'b1; tick("s2"); start = 1'b0;
      tick("s2_gen"); tick("s2_wait");
      correct_round("s2_round", 32'hDEAD_BEEF);
      #2;
      rst_n = 1'b0;
      #1;
      ph = M_IDLE;
      score = 0;
      check_outputs("midgame_rst");
      chk("midgame_rst_count", {16'b0, count}, 32'h0);
      tick("midgame_rst_hold");
      rst_n = 1'b1;
      tick("post_rst_idle");

      // Counter wrap
      start = 1'b1; tick("s3"); start = 1'b0;
      tick("s3_gen"); tick("s3_wait");
      force dut.count_q = 16'hFFFF;
      #1;
      release dut.count_q;
      score = 16'hFFFF;
      chk("preload", {16'b0, count}, 32'h0000_FFFF);
      correct_round("wrap", 32'h8000_0001);
      chk("wrap_count", {16'b0, count}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

endmodule
